// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS opcode constants, instruction-kind and loader-state enums
package mips_isa_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_J    = 3'd1,
    KIND_LW   = 3'd2,
    KIND_SW   = 3'd3,
    KIND_BEQ  = 3'd4,
    KIND_ADDI = 3'd5,
    KIND_ORI  = 3'd6,
    KIND_JAL  = 3'd7
  } instr_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - combinational field-to-word MIPS instruction encoder
module mips_instr_encoder
  import mips_isa_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    case (instr_kind_e'(kind_i))
      KIND_R:    word_o = {OP_R, rs_i, rt_i, rd_i, shamt_i, funct_i};
      KIND_J:    word_o = {OP_J, target_i};
      KIND_JAL:  word_o = {OP_JAL, target_i};
      KIND_LW:   word_o = {OP_LW, rs_i, rt_i, imm_i};
      KIND_SW:   word_o = {OP_SW, rs_i, rt_i, imm_i};
      KIND_BEQ:  word_o = {OP_BEQ, rs_i, rt_i, imm_i};
      KIND_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm_i};
      KIND_ORI:  word_o = {OP_ORI, rs_i, rt_i, imm_i};
      default:   word_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_imem_loader.sv
// rtl/mips_imem_loader.sv - assembles instructions into imem, holds core in reset until done; LOADER_CHECKSUM_EN adds XOR checksum
module mips_imem_loader
  import mips_isa_pkg::*;
#(
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  index_q, index_d;
  logic [CNT_W-1:0]  wc_q, wc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       enc_word;
  logic              full;
  logic              accept;

  mips_instr_encoder u_encoder (
    .kind_i   (in_kind),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .shamt_i  (in_shamt),
    .funct_i  (in_funct),
    .imm_i    (in_imm),
    .target_i (in_target),
    .word_o   (enc_word)
  );

  // Capacity is judged on accepted words; word_count lags by the write stage.
  assign full     = (index_q == DEPTH_C);
  assign in_ready = (state_q == ST_LOAD) && !full;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    wc_d    = we_q ? wc_q + CNT_W'(1) : wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          index_d = '0;
          wc_d    = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + ADDR_W'({index_q, 2'b00});
          wdata_d = enc_word;
          index_d = index_q + CNT_W'(1);
          if (in_last) state_d = ST_FLUSH;
        end else if (full && in_valid) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if ((state_q == ST_IDLE || state_q == ST_DONE) && start) chk_d = '0;
    else if (we_q) chk_d = chk_q ^ wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) chk_q <= '0;
    else       chk_q <= chk_d;
  end

  assign checksum = chk_q;
`endif

  // A start seen in DONE re-asserts core reset in the same cycle.
  assign done       = (state_q == ST_DONE) && !start;
  assign cpu_reset  = !done;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err        = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// tb/tb_mips_imem_loader.sv - directed self-checking bench for mips_imem_loader
module tb_mips_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, imem_we, cpu_reset, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [8:0]  word_count;
  logic        in_ready2, imem_we2, cpu_reset2, done2, err2;
  logic [31:0] imem_addr2, imem_wdata2;
  logic [1:0]  word_count2;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum, checksum2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .word_count(word_count)
  );

  mips_imem_loader #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_last(in_last), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .cpu_reset(cpu_reset2), .done(done2), .err(err2),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum2),
`endif
    .word_count(word_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                       input logic [25:0] target, input logic last);
    in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = 5'd0;
    in_funct = funct; in_imm = imm; in_target = target; in_last = last; in_valid = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    drive(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wc", word_count, 0);

    // single R-type add
    pulse_start();
    check("load_ready", in_ready, 1);
    check("load_cpu_reset", cpu_reset, 1);
    drive(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("r_we", imem_we, 1);
    check("r_addr", imem_addr, 32'h0);
    check("r_wdata", imem_wdata, 32'h00221820);
    check("r_done_early", done, 0);
    @(negedge clk);
    check("r_done", done, 1);
    check("r_cpu_reset", cpu_reset, 0);
    check("r_we_off", imem_we, 0);
    check("r_wc", word_count, 1);

    // restart from DONE: core goes back into reset in the start cycle
    start = 1'b1;
    #1;
    check("restart_done", done, 0);
    check("restart_cpu_reset", cpu_reset, 1);
    @(negedge clk);
    start = 1'b0;

    // back-to-back lw / beq / ori
    drive(3'd2, 5'd9, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
    @(negedge clk);
    check("lw_we", imem_we, 1);
    check("lw_addr", imem_addr, 32'h0);
    check("lw_wdata", imem_wdata, 32'h8D280004);
    drive(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    @(negedge clk);
    check("beq_we", imem_we, 1);
    check("beq_addr", imem_addr, 32'h4);
    check("beq_wdata", imem_wdata, 32'h1022FFFF);
    drive(3'd6, 5'd0, 5'd5, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("ori_we", imem_we, 1);
    check("ori_addr", imem_addr, 32'h8);
    check("ori_wdata", imem_wdata, 32'h340500FF);
    @(negedge clk);
    check("b2b_done", done, 1);
    check("b2b_wc", word_count, 3);
    check("b2b_err", err, 0);

    // j then jal, with a start pulse mid-load that must be ignored
    pulse_start();
    drive(3'd1, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("j_wdata", imem_wdata, 32'h08000010);
    check("j_addr", imem_addr, 32'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h100, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("jal_wdata", imem_wdata, 32'h0C000100);
    check("jal_addr", imem_addr, 32'h4);
    @(negedge clk);
    check("jal_done", done, 1);
    check("jal_wc", word_count, 2);

    // DEPTH=2 overflow on dut2 with three words and no last
    pulse_start();
    check("ovf_ready0", in_ready2, 1);
    check("ovf_err_clr", err2, 0);
    drive(3'd5, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
    @(negedge clk);
    check("ovf_we1", imem_we2, 1);
    check("ovf_wdata1", imem_wdata2, 32'h20210001);
    drive(3'd3, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0);
    @(negedge clk);
    check("ovf_we2", imem_we2, 1);
    check("ovf_addr2", imem_addr2, 32'h4);
    check("ovf_wdata2", imem_wdata2, 32'hAC430008);
    check("ovf_ready_full", in_ready2, 0);
    check("ovf_err_pending", err2, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("ovf_err", err2, 1);
    check("ovf_done", done2, 1);
    check("ovf_we_none", imem_we2, 0);
    check("ovf_wc", word_count2, 2);

    // reset the cycle after an accept drops the pending write
    drive(3'd5, 5'd0, 5'd4, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0);
    @(negedge clk);
    check("abort_we_pre", imem_we, 1);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_we", imem_we, 0);
    check("abort_cpu_reset", cpu_reset, 1);
    check("abort_wc", word_count, 0);
    check("abort_idle_ready", in_ready, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_stays_idle", in_ready, 0);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    drive(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b0);
    @(negedge clk);
    drive(3'd2, 5'd9, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("chk_done", done, 1);
    check("chk_value", checksum, 32'h8D0A1824);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
